// File: rtl/pkg_config.sv
// ============================================================================
// pkg_config : shared rv32i core configuration, fetch types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package pkg_config;

  localparam int INST_WIDTH = 32;
  localparam int XLEN       = 32;

  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Next-PC source selected by the fetch FSM
  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_gen.sv
// ============================================================================
// fetch_pc_gen : next-PC mux (hold / pc+4 / redirect) and target alignment check
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_pc_gen
  import pkg_config::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  pc_sel_e         i_sel,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_target_aligned
);

  assign o_pc_plus4       = i_pc + 32'd4;
  assign o_target_aligned = (i_redirect_pc[1:0] == 2'b00);

  always_comb begin
    o_next_pc = i_pc;
    case (i_sel)
      PC_INC:      o_next_pc = o_pc_plus4;
      PC_REDIRECT: o_next_pc = i_redirect_pc;
      default:     o_next_pc = i_pc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : rv32i instruction fetch, PC register, IF/ID register, fetch count
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import pkg_config::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [XLEN-1:0]       redirect_pc_i,
  output logic [IMEM_AW-1:0]    imem_addr_o,
  input  logic [INST_WIDTH-1:0] imem_inst_i,
  output logic                  if_valid_o,
  output logic [XLEN-1:0]       if_pc_o,
  output logic [XLEN-1:0]       if_pc_plus4_o,
  output logic [INST_WIDTH-1:0] if_inst_o,
  output logic                  if_fault_o,
  output logic [31:0]           fetch_count_o
);

  fetch_state_e r_state, w_state_next;

  logic [XLEN-1:0]       r_pc;
  logic                  r_valid;
  logic [XLEN-1:0]       r_if_pc;
  logic [XLEN-1:0]       r_if_pc_plus4;
  logic [INST_WIDTH-1:0] r_if_inst;
  logic                  r_fault;
  logic [31:0]           r_count;

  pc_sel_e         w_pc_sel;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_aligned;
  logic            w_capture;
  logic            w_flush;
  logic            w_kill;
  logic            w_set_fault;
  logic            w_clr_fault;

  fetch_pc_gen u_pc_gen (
    .i_pc             (r_pc),
    .i_sel            (w_pc_sel),
    .i_redirect_pc    (redirect_pc_i),
    .o_pc_plus4       (w_pc_plus4),
    .o_next_pc        (w_next_pc),
    .o_target_aligned (w_aligned)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= BOOT;
    else         r_state <= w_state_next;
  end

  // Redirects outrank stalls; a misaligned target parks the stage in HALT
  always_comb begin
    w_state_next = r_state;
    w_pc_sel     = PC_HOLD;
    w_capture    = 1'b0;
    w_flush      = 1'b0;
    w_kill       = 1'b0;
    w_set_fault  = 1'b0;
    w_clr_fault  = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_next = RUN;
        if (redirect_i) begin
          if (w_aligned) begin
            w_pc_sel = PC_REDIRECT;
          end else begin
            w_set_fault  = 1'b1;
            w_state_next = HALT;
          end
        end
      end
      RUN: begin
        if (redirect_i) begin
          if (w_aligned) begin
            w_pc_sel = PC_REDIRECT;
            w_flush  = 1'b1;
          end else begin
            w_kill       = 1'b1;
            w_set_fault  = 1'b1;
            w_state_next = HALT;
          end
        end else if (!stall_i) begin
          w_pc_sel  = PC_INC;
          w_capture = 1'b1;
        end
      end
      HALT: begin
        if (redirect_i && w_aligned) begin
          w_pc_sel     = PC_REDIRECT;
          w_clr_fault  = 1'b1;
          w_state_next = RUN;
        end
      end
      default: w_state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc          <= RESET_PC;
      r_valid       <= 1'b0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_if_inst     <= NOP_INST;
      r_fault       <= 1'b0;
      r_count       <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_capture) begin
        r_valid       <= 1'b1;
        r_if_pc       <= r_pc;
        r_if_pc_plus4 <= w_pc_plus4;
        r_if_inst     <= imem_inst_i;
        r_count       <= r_count + 32'd1;
      end else if (w_flush) begin
        r_valid   <= 1'b0;
        r_if_inst <= NOP_INST;
      end else if (w_kill) begin
        r_valid <= 1'b0;
      end
      if (w_set_fault)      r_fault <= 1'b1;
      else if (w_clr_fault) r_fault <= 1'b0;
    end
  end

  assign imem_addr_o   = r_pc[IMEM_AW-1:0];
  assign if_valid_o    = r_valid;
  assign if_pc_o       = r_if_pc;
  assign if_pc_plus4_o = r_if_pc_plus4;
  assign if_inst_o     = r_if_inst;
  assign if_fault_o    = r_fault;
  assign fetch_count_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : scoreboard bench for fetch_stage with a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_inst;
  logic        if_fault;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  // Model state: mode 0 = booting, 1 = running, 2 = halted
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_fault;
  logic        m_valid;

  always #5 clk = ~clk;

  // ROM word i holds 32'h1000_0000 + i
  assign imem_inst = 32'h1000_0000 + {24'b0, imem_addr[9:2]};

  fetch_stage dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_inst_i   (imem_inst),
    .if_valid_o    (if_valid),
    .if_pc_o       (if_pc),
    .if_pc_plus4_o (if_pc_plus4),
    .if_inst_o     (if_inst),
    .if_fault_o    (if_fault),
    .fetch_count_o (fetch_count)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + ((a % 1024) / 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 32'h0;
    m_count = 0;
    m_fault = 1'b0;
    m_valid = 1'b0;
    sb.delete();
  endtask

  task automatic chk_reset_values();
    chk("rst_valid", {31'b0, if_valid}, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_pc4", if_pc_plus4, 0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_fault", {31'b0, if_fault}, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_addr", {22'b0, imem_addr}, 0);
  endtask

  // Decode consumes IF/ID on any cycle it is valid and not stalled
  always @(negedge clk) begin
    if (rst_ni && if_valid && !stall) begin
      if (sb.size() == 0) begin
        chk("unexpected_delivery", if_pc, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("deliver_pc", if_pc, e.pc);
        chk("deliver_pc4", if_pc_plus4, e.pc4);
        chk("deliver_inst", if_inst, e.inst);
      end
    end
  end

  // Drive one cycle, advance the model by the rules of the stage, compare state
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
    logic nop_exp;
    stall       = st;
    redirect    = rd;
    redirect_pc = tgt;
    @(posedge clk);
    #1;
    nop_exp = 1'b0;
    if (m_mode == 0) begin
      if (rd && (tgt % 4) != 0) begin
        m_fault = 1'b1;
        m_mode  = 2;
      end else begin
        if (rd) m_pc = tgt;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (rd) begin
        if (m_valid && st) void'(sb.pop_back());
        m_valid = 1'b0;
        if ((tgt % 4) == 0) begin
          m_pc    = tgt;
          nop_exp = 1'b1;
        end else begin
          m_fault = 1'b1;
          m_mode  = 2;
        end
      end else if (!st) begin
        m_valid = 1'b1;
        sb.push_back('{m_pc, m_pc + 32'd4, rom(m_pc)});
        m_pc    = m_pc + 32'd4;
        m_count = m_count + 32'd1;
      end
    end else begin
      if (rd && (tgt % 4) == 0) begin
        m_pc    = tgt;
        m_fault = 1'b0;
        m_mode  = 1;
      end
    end
    chk("valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("fault", {31'b0, if_fault}, {31'b0, m_fault});
    chk("count", fetch_count, m_count);
    chk("imem_addr", {22'b0, imem_addr}, m_pc % 1024);
    if (nop_exp) chk("flush_nop", if_inst, NOP);
  endtask

  initial begin
    logic [31:0] tgt;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values();
    @(negedge clk);
    rst_ni = 1'b1;

    // Boot then two fetches
    step(0, 0, 0);
    chk("boot_no_valid", {31'b0, if_valid}, 0);
    step(0, 0, 0);
    chk("first_pc", if_pc, 0);
    chk("first_inst", if_inst, 32'h1000_0000);
    step(0, 0, 0);
    chk("second_pc", if_pc, 4);
    chk("second_inst", if_inst, 32'h1000_0001);
    chk("count_two", fetch_count, 2);

    // Stall at pc 8
    repeat (3) begin
      step(1, 0, 0);
      chk("stall_if_pc", if_pc, 4);
      chk("stall_addr", {22'b0, imem_addr}, 8);
      chk("stall_count", fetch_count, 2);
    end
    step(0, 0, 0);
    chk("resume_pc8", if_pc, 8);
    step(0, 0, 0);
    chk("resume_pc12", if_pc, 12);

    // Redirect overriding a stall
    step(1, 1, 32'h40);
    chk("redir_inst_nop", if_inst, NOP);
    step(0, 0, 0);
    chk("redir_target_pc", if_pc, 32'h40);
    chk("redir_target_inst", if_inst, 32'h1000_0010);

    // Misaligned target halts, aligned target recovers
    step(0, 1, 32'h42);
    chk("halt_fault", {31'b0, if_fault}, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("halt_hold_valid", {31'b0, if_valid}, 0);
    step(0, 1, 32'h80);
    chk("recover_fault", {31'b0, if_fault}, 0);
    step(0, 0, 0);
    chk("recover_pc", if_pc, 32'h80);
    chk("recover_inst", if_inst, 32'h1000_0020);

    // Reach pc 0x20 then reset between edges
    step(0, 1, 32'h18);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("pre_reset_addr", {22'b0, imem_addr}, 32'h20);
    stall    = 1'b0;
    redirect = 1'b0;
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    chk_reset_values();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("post_reset_pc", if_pc, 0);

    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc_plus4, 0);
    chk("wrap_addr", {22'b0, imem_addr}, 0);
    step(0, 0, 0);
    chk("wrap_next_pc", if_pc, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic st, rd;
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 4) != 0) tgt = tgt & 32'hFFFF_FFFC;
      step(st, rd, tgt);
    end
    stall    = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
